// File: rtl/uart_pkg.sv
// Shared definitions for the UART text printers: ASCII constants, frame FSM
// state encoding and the nibble-to-hex helper.
package uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } frame_state_t;

    // Uppercase hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    function automatic logic [7:0] nibble_to_hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational 4-bit to uppercase ASCII hex encoder, shared by the text
// printers (UART, LCD, debug).
module hex_ascii_enc
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_hex_ascii(nibble);

endmodule

// File: rtl/uart_hex_frame_tx.sv
// Snapshots NUM_WORDS words on start and streams them to uart_tx as uppercase
// hex text, words separated by SEP, line ended by CR LF (or LF only).
//
//   state    | meaning
//   ST_IDLE  | waiting for start, tx_data_valid low
//   ST_DIGIT | presenting the top nibble of the snapshot as a hex digit
//   ST_SEP   | presenting the separator between two words
//   ST_CR    | presenting carriage return
//   ST_LF    | presenting line feed; its transfer ends the frame
module uart_hex_frame_tx
    import uart_pkg::*;
#(
    parameter int         WORD_WIDTH = 32,
    parameter int         NUM_WORDS  = 1,
    parameter logic [7:0] SEP        = ASCII_SPACE,
    parameter bit         EOL_CRLF   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] words_in,
    output logic [7:0]                      tx_data,
    output logic                            tx_data_valid,
    input  logic                            tx_data_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            missed
);

    localparam int TOTAL = NUM_WORDS * WORD_WIDTH;
    localparam int NIB_W = $clog2(WORD_WIDTH / 4) + 1;
    localparam int WRD_W = $clog2(NUM_WORDS) + 1;
    localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(WORD_WIDTH / 4 - 1);
    localparam logic [WRD_W-1:0] WORD_LAST = WRD_W'(NUM_WORDS - 1);

    frame_state_t     state;
    logic [TOTAL-1:0] snap;
    logic [TOTAL-1:0] words_rev;
    logic [TOTAL-1:0] snap_shl;
    logic [NIB_W-1:0] nib_cnt;
    logic [WRD_W-1:0] word_cnt;
    logic [3:0]       next_nib;
    logic [7:0]       next_digit;
    logic             xfer;

    // Word 0 goes to the top of the snapshot so the digit to print is always
    // the top nibble; each digit transfer shifts the whole snapshot by 4.
    always_comb begin
        words_rev = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            words_rev[(NUM_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH] = words_in[i*WORD_WIDTH +: WORD_WIDTH];
    end

    assign snap_shl = snap << 4;
    assign xfer     = tx_data_valid && tx_data_ready;

    always_comb begin
        next_nib = snap[TOTAL-1 -: 4];
        if (state == ST_IDLE)
            next_nib = words_rev[TOTAL-1 -: 4];
        else if (state == ST_DIGIT)
            next_nib = snap_shl[TOTAL-1 -: 4];
    end

    hex_ascii_enc u_enc (
        .nibble (next_nib),
        .ascii  (next_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            snap          <= '0;
            nib_cnt       <= '0;
            word_cnt      <= '0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            missed        <= 1'b0;
        end else begin
            done   <= 1'b0;
            missed <= start && busy;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap          <= words_rev;
                        nib_cnt       <= '0;
                        word_cnt      <= '0;
                        tx_data       <= next_digit;
                        tx_data_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (xfer) begin
                        snap <= snap_shl;
                        if (nib_cnt != NIB_LAST) begin
                            nib_cnt <= nib_cnt + 1'b1;
                            tx_data <= next_digit;
                        end else if (word_cnt != WORD_LAST) begin
                            tx_data <= SEP;
                            state   <= ST_SEP;
                        end else if (EOL_CRLF) begin
                            tx_data <= ASCII_CR;
                            state   <= ST_CR;
                        end else begin
                            tx_data <= ASCII_LF;
                            state   <= ST_LF;
                        end
                    end
                end
                ST_SEP: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + 1'b1;
                        nib_cnt  <= '0;
                        tx_data  <= next_digit;
                        state    <= ST_DIGIT;
                    end
                end
                ST_CR: begin
                    if (xfer) begin
                        tx_data <= ASCII_LF;
                        state   <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (xfer) begin
                        tx_data       <= 8'h00;
                        tx_data_valid <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    tx_data_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_frame_tx.sv
// Bench for uart_hex_frame_tx: a 32x1 CRLF instance and a 16x2 LF-only instance,
// checked against a vector table and a hex-text reference model.
`timescale 1ns/100ps
module tb_uart_hex_frame_tx;

    logic        clk;
    logic        rst_n;
    logic        start  [2];
    logic [31:0] words  [2];
    logic        ready  [2];
    logic [7:0]  data   [2];
    logic        valid  [2];
    logic        busy   [2];
    logic        done   [2];
    logic        missed [2];

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int done_cnt   [2];
    int missed_cnt [2];
    int exp_done   [2];
    logic       stall_prev [2];
    logic [7:0] data_prev  [2];

    typedef struct {
        int          sel;
        logic [31:0] words;
        int          stall;
        int          len;
        logic [79:0] exp;
    } vec_t;
    vec_t tbl [6];

    uart_hex_frame_tx #(.WORD_WIDTH(32), .NUM_WORDS(1), .SEP(8'h20), .EOL_CRLF(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .words_in(words[0]),
        .tx_data(data[0]), .tx_data_valid(valid[0]), .tx_data_ready(ready[0]),
        .busy(busy[0]), .done(done[0]), .missed(missed[0])
    );

    uart_hex_frame_tx #(.WORD_WIDTH(16), .NUM_WORDS(2), .SEP(8'h20), .EOL_CRLF(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .words_in(words[1]),
        .tx_data(data[1]), .tx_data_valid(valid[1]), .tx_data_ready(ready[1]),
        .busy(busy[1]), .done(done[1]), .missed(missed[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte collection and handshake-hold checks, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                if (stall_prev[k]) begin
                    total++;
                    if (!(valid[k] && data[k] == data_prev[k])) begin
                        bad++;
                        $display("FAIL hold%0d: valid=%0b data=%h, required valid=1 data=%h",
                                 k, valid[k], data[k], data_prev[k]);
                    end
                end
                stall_prev[k] = valid[k] && !ready[k];
                data_prev[k]  = data[k];
                if (valid[k] && ready[k]) begin
                    if (k == 0) got0.push_back(data[k]);
                    else        got1.push_back(data[k]);
                end
                if (done[k])   done_cnt[k]++;
                if (missed[k]) missed_cnt[k]++;
            end else begin
                stall_prev[k] = 1'b0;
            end
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_frame(input int sel, input string name);
        logic [7:0] g[$];
        int bad_i;
        if (sel == 0) g = got0; else g = got1;
        bad_i = -1;
        for (int i = 0; i < exp_q.size() || i < g.size(); i++)
            if (bad_i < 0 && (i >= g.size() || i >= exp_q.size() || g[i] != exp_q[i]))
                bad_i = i;
        total++;
        if (bad_i >= 0) begin
            bad++;
            $display("FAIL %s: got %0d bytes (byte%0d=%h), required %0d bytes (byte%0d=%h)",
                     name, g.size(), bad_i, (bad_i < g.size()) ? g[bad_i] : 8'hxx,
                     exp_q.size(), bad_i, (bad_i < exp_q.size()) ? exp_q[bad_i] : 8'hxx);
        end
    endtask

    // Reference: each word as WORD_WIDTH/4 uppercase hex digits, MSB first.
    function automatic void build_exp(input int sel, input logic [31:0] w);
        int ww;
        int nw;
        int nib;
        longint unsigned wv;
        ww = (sel == 0) ? 32 : 16;
        nw = (sel == 0) ? 1 : 2;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            wv = (longint'(w) >> (i * ww)) & ((64'd1 << ww) - 1);
            for (int d = ww / 4 - 1; d >= 0; d--) begin
                nib = int'((wv >> (4 * d)) & 64'd15);
                exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
            end
            if (i < nw - 1) exp_q.push_back(8'h20);
        end
        if (sel == 0) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void load_exp(input int idx);
        logic [79:0] e;
        e = tbl[idx].exp;
        exp_q.delete();
        for (int b = 0; b < tbl[idx].len; b++)
            exp_q.push_back(e[8*(tbl[idx].len-1-b) +: 8]);
    endfunction

    function automatic logic ready_for(input int stall, input int c);
        if (stall == 0) return 1'b1;
        if (stall < 0)  return $urandom_range(0, 3) != 0;
        return (c % (stall + 1)) == 0;
    endfunction

    // Cycle c is the c-th cycle after the start edge; done_n is the cycle in
    // which done is seen, busy_n the number of cycles busy was seen high.
    task automatic run_frame(input int sel, input logic [31:0] w, input int stall, input int mid,
                             output int done_n, output int busy_n);
        if (sel == 0) got0.delete(); else got1.delete();
        exp_done[sel]++;
        words[sel] = w;
        ready[sel] = ready_for(stall, 1);
        start[sel] = 1'b1;
        @(posedge clk);
        #1 start[sel] = 1'b0;
        done_n = -1;
        busy_n = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (busy[sel]) busy_n++;
            if (done[sel]) begin
                done_n = c;
                break;
            end
            @(posedge clk);
            #1;
            ready[sel] = ready_for(stall, c + 1);
            start[sel] = (c + 1 == mid);
            if (c + 1 == mid) words[sel] = '1;
        end
        if (done_n < 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout%0d: no done in 400 cycles, required done", sel);
        end
        #1;
    endtask

    initial begin
        int dn, bn, m0, sel;
        logic [31:0] w;

        tbl[0] = '{0, 32'h00A01FF3, 0, 10, 80'h30304130314646330D0A};
        tbl[1] = '{1, 32'hBEEF0012, 0, 10, 80'h3030313220424545460A};
        tbl[2] = '{0, 32'h00A01FF3, 5, 10, 80'h30304130314646330D0A};
        tbl[3] = '{0, 32'h0000000F, 0, 10, 80'h30303030303030460D0A};
        tbl[4] = '{1, 32'h0000FFFF, 0, 10, 80'h4646464620303030300A};
        tbl[5] = '{0, 32'hFFFFFFFF, 2, 10, 80'h46464646464646460D0A};

        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; words[k] = '0; ready[k] = 1'b0;
            done_cnt[k] = 0; missed_cnt[k] = 0; exp_done[k] = 0;
            stall_prev[k] = 1'b0; data_prev[k] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check_int("rst_tx_data", int'(data[k]), 0);
            check_int("rst_valid", int'(valid[k]), 0);
            check_int("rst_busy", int'(busy[k]), 0);
            check_int("rst_done", int'(done[k]), 0);
            check_int("rst_missed", int'(missed[k]), 0);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            load_exp(i);
            run_frame(tbl[i].sel, tbl[i].words, tbl[i].stall, -1, dn, bn);
            check_frame(tbl[i].sel, $sformatf("tbl%0d_bytes", i));
            check_int($sformatf("tbl%0d_done_cycle", i), dn, tbl[i].len * (tbl[i].stall + 1) + 1);
            check_int($sformatf("tbl%0d_busy_cycles", i), bn, tbl[i].len * (tbl[i].stall + 1));
        end

        // Second start during the frame plus words_in change: ignored, missed once.
        m0 = missed_cnt[0];
        load_exp(0);
        run_frame(0, 32'h00A01FF3, 0, 4, dn, bn);
        check_frame(0, "busy_start_bytes");
        check_int("busy_start_missed", missed_cnt[0] - m0, 1);
        check_int("busy_start_done_cycle", dn, 11);

        // Reset after three transfers abandons the frame immediately.
        got0.delete();
        words[0] = 32'h00A01FF3;
        ready[0] = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_int("pre_reset_bytes", got0.size(), 3);
        check_int("pre_reset_busy", int'(busy[0]), 1);
        rst_n = 1'b0;
        #0.5;
        check_int("mid_reset_valid", int'(valid[0]), 0);
        check_int("mid_reset_busy", int'(busy[0]), 0);
        check_int("mid_reset_done", int'(done[0]), 0);
        #0.5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_exp(0);
        run_frame(0, 32'h00A01FF3, 0, -1, dn, bn);
        check_frame(0, "post_reset_bytes");
        check_int("post_reset_done_cycle", dn, 11);

        // Start in the done cycle: accepted as a back-to-back frame.
        m0 = missed_cnt[0];
        load_exp(0);
        run_frame(0, 32'h00A01FF3, 0, -1, dn, bn);
        check_frame(0, "b2b_first_bytes");
        load_exp(3);
        run_frame(0, 32'h0000000F, 0, -1, dn, bn);
        check_frame(0, "b2b_second_bytes");
        check_int("b2b_second_done_cycle", dn, 11);
        check_int("b2b_missed", missed_cnt[0] - m0, 0);

        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 1));
            w = $urandom;
            build_exp(sel, w);
            run_frame(sel, w, -1, -1, dn, bn);
            check_frame(sel, $sformatf("rand%0d_sel%0d_%h", n, sel, w));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check_int("done_pulses0", done_cnt[0], exp_done[0]);
        check_int("done_pulses1", done_cnt[1], exp_done[1]);
        check_int("missed_total0", missed_cnt[0], 1);
        check_int("missed_total1", missed_cnt[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
